// File: rtl/fighter_sprite_animator.sv
// Animation engine for one fighter: pose/frame sequencing on vblank ticks, plus a
// registered sprite ROM address with an on-flag aligned to the ROM read data.
module fighter_sprite_animator #(
  parameter int SPR_W           = 64,
  parameter int SPR_H           = 96,
  parameter int NUM_POSES       = 4,
  parameter int FRAMES_PER_POSE = 4,
  parameter int TICKS_PER_FRAME = 6,
  parameter logic [NUM_POSES-1:0] LOOP_MASK = 4'b0001,
  parameter int ADDR_W          = 17,
  localparam int PW = (NUM_POSES > 1) ? $clog2(NUM_POSES) : 1,
  localparam int FW = (FRAMES_PER_POSE > 1) ? $clog2(FRAMES_PER_POSE) : 1
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [PW-1:0]     pose_req,
  input  logic              pose_req_valid,
  input  logic              facing_left,
  input  logic [9:0]        RyuX,
  input  logic [9:0]        RyuY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              ryu_on,
  output logic [PW-1:0]     pose,
  output logic [FW-1:0]     frame,
  output logic              busy
);
  localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [9:0] SW10 = 10'(SPR_W);
  localparam logic [9:0] SH10 = 10'(SPR_H);

  // busy is exactly (state == S_ONESHOT); it is the externally visible state.
  typedef enum logic {S_LOOP, S_ONESHOT} state_t;
  state_t state, state_n;

  logic [PW-1:0] pose_n, pend, pend_n, eff;
  logic [FW-1:0] frame_n;
  logic [TW-1:0] tick, tick_n;
  logic          pend_v, pend_v_n, busy_n;
  logic          req_ok, eff_v, eff_loops, last_tick, last_frame;
  logic          facing_l, in_spr, in_d;
  logic [9:0]    rx_l, ry_l, dx, dy, xo;
  logic [ADDR_W-1:0] addr_n;

  always_comb begin
    state_n    = state;
    pose_n     = pose;
    frame_n    = frame;
    tick_n     = tick;
    pend_n     = pend;
    pend_v_n   = pend_v;
    busy_n     = busy;
    req_ok     = pose_req_valid && (32'(pose_req) < NUM_POSES);
    eff_v      = req_ok || pend_v;
    eff        = req_ok ? pose_req : pend;
    eff_loops  = (eff == '0) || LOOP_MASK[eff];
    last_tick  = (32'(tick) == TICKS_PER_FRAME - 1);
    last_frame = (32'(frame) == FRAMES_PER_POSE - 1);
    if (req_ok) begin
      pend_n   = pose_req;
      pend_v_n = 1'b1;
    end
    if (frame_start) begin
      if (state == S_LOOP && eff_v && eff != pose) begin
        pose_n   = eff;
        frame_n  = '0;
        tick_n   = '0;
        pend_v_n = 1'b0;
        state_n  = eff_loops ? S_LOOP : S_ONESHOT;
        busy_n   = !eff_loops;
      end else begin
        // A request for the pose already looping is simply dropped.
        if (state == S_LOOP && eff_v) pend_v_n = 1'b0;
        if (!last_tick) begin
          tick_n = tick + 1'b1;
        end else begin
          tick_n = '0;
          if (!last_frame) begin
            frame_n = frame + 1'b1;
          end else begin
            frame_n = '0;
            if (state == S_ONESHOT) begin
              pose_n  = '0;
              state_n = S_LOOP;
              busy_n  = 1'b0;
            end
          end
        end
      end
    end
  end

  // Beam-relative coordinates; the ">=" terms keep negative offsets from wrapping in.
  always_comb begin
    dx     = DrawX - rx_l;
    dy     = DrawY - ry_l;
    in_spr = blank && (DrawX >= rx_l) && (dx < SW10) && (DrawY >= ry_l) && (dy < SH10);
    xo     = facing_l ? (SW10 - 10'd1 - dx) : dx;
    addr_n = (ADDR_W'(pose) * ADDR_W'(FRAMES_PER_POSE) + ADDR_W'(frame))
               * ADDR_W'(SPR_W * SPR_H)
           + ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(xo);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state    <= S_LOOP;
      pose     <= '0;
      frame    <= '0;
      tick     <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      busy     <= 1'b0;
      facing_l <= 1'b0;
      rx_l     <= '0;
      ry_l     <= '0;
      rom_addr <= '0;
      in_d     <= 1'b0;
      ryu_on   <= 1'b0;
    end else begin
      state    <= state_n;
      pose     <= pose_n;
      frame    <= frame_n;
      tick     <= tick_n;
      pend     <= pend_n;
      pend_v   <= pend_v_n;
      busy     <= busy_n;
      if (frame_start) begin
        facing_l <= facing_left;
        rx_l     <= RyuX;
        ry_l     <= RyuY;
      end
      rom_addr <= in_spr ? addr_n : '0;
      in_d     <= in_spr;
      ryu_on   <= in_d;
    end
  end
endmodule
